// File: rtl/spi_transfer_ctrl.sv
// SPI master byte-transfer engine: SETUP / 16 sclk edges / DONE, all timed by the half period H.
// Optional macro SPI_WAIT_FREEZE_EN freezes an in-flight transfer while in wait mode with spiswai set.
module spi_transfer_ctrl (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       send_data,
    input  logic [7:0] mosi_data,
    input  logic       mstr,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic       spiswai,
    input  logic [1:0] spi_mode,
    input  logic [2:0] spr,
    input  logic [2:0] sppr,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic       tip,
    output logic       receive_data,
    output logic [7:0] miso_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_DONE} state_t;

    state_t       r_state;
    state_t       w_next;

    logic         r_sclk;
    logic         r_mosi;
    logic         r_ss;
    logic         r_tip;
    logic         r_rx_vld;
    logic [7:0]   r_miso_data;
    logic [10:0]  r_cnt;
    logic [10:0]  r_half;
    logic [3:0]   r_edge;
    logic [7:0]   r_tx;
    logic [7:0]   r_rx;
    logic         r_cpha;
    logic         r_lsbfe;

    logic [10:0]  w_half;
    logic         w_freeze;
    logic         w_run;
    logic         w_tick;
    logic         w_start;
    logic         w_edge_ev;
    logic         w_lead;
    logic         w_shift_tx;
    logic         w_sample;
    logic         w_tx_bit;

`ifdef SPI_WAIT_FREEZE_EN
    assign w_freeze = (spi_mode == 2'b01) && spiswai;
`else
    logic w_unused;
    assign w_unused = spiswai;
    assign w_freeze = 1'b0;
`endif

    // H = (sppr+1) << spr spans 1..1024, so 11 bits never overflow
    assign w_half     = ({8'd0, sppr} + 11'd1) << spr;
    assign w_run      = !w_freeze;
    assign w_tick     = (r_cnt == 11'd0);
    // no restart in the cycle the completion pulse is visible
    assign w_start    = (r_state == ST_IDLE) && send_data && mstr &&
                        (spi_mode == 2'b00) && !r_rx_vld;
    assign w_edge_ev  = (r_state == ST_XFER) && w_run && w_tick;
    assign w_lead     = !r_edge[0];
    assign w_shift_tx = w_edge_ev && (r_cpha ? w_lead : (!w_lead && (r_edge != 4'd15)));
    assign w_sample   = w_edge_ev && (r_cpha ? !w_lead : w_lead);
    assign w_tx_bit   = r_lsbfe ? r_tx[0] : r_tx[7];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_SETUP;
            ST_SETUP: if (w_run && w_tick) w_next = ST_XFER;
            ST_XFER:  if (w_edge_ev && (r_edge == 4'd15)) w_next = ST_DONE;
            ST_DONE:  if (w_run && w_tick) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_ss        <= 1'b1;
            r_tip       <= 1'b0;
            r_rx_vld    <= 1'b0;
            r_miso_data <= 8'h00;
            r_cnt       <= 11'd0;
            r_half      <= 11'd0;
            r_edge      <= 4'd0;
            r_tx        <= 8'h00;
            r_rx        <= 8'h00;
            r_cpha      <= 1'b0;
            r_lsbfe     <= 1'b0;
        end else begin
            r_rx_vld <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_sclk <= cpol;
                r_mosi <= 1'b0;
                r_ss   <= 1'b1;
                r_tip  <= 1'b0;
                if (w_start) begin
                    r_ss    <= 1'b0;
                    r_tip   <= 1'b1;
                    r_half  <= w_half;
                    r_cnt   <= w_half - 11'd1;
                    r_edge  <= 4'd0;
                    r_rx    <= 8'h00;
                    r_cpha  <= cpha;
                    r_lsbfe <= lsbfe;
                    // cpha=0 presents the first bit before any sclk edge
                    if (cpha) begin
                        r_tx <= mosi_data;
                    end else begin
                        r_mosi <= lsbfe ? mosi_data[0] : mosi_data[7];
                        r_tx   <= lsbfe ? {1'b0, mosi_data[7:1]} : {mosi_data[6:0], 1'b0};
                    end
                end
            end else if (w_run) begin
                r_cnt <= w_tick ? (r_half - 11'd1) : (r_cnt - 11'd1);
                if (w_edge_ev) begin
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + 4'd1;
                end
                if (w_shift_tx) begin
                    r_mosi <= w_tx_bit;
                    r_tx   <= r_lsbfe ? {1'b0, r_tx[7:1]} : {r_tx[6:0], 1'b0};
                end
                if (w_sample)
                    r_rx <= r_lsbfe ? {miso, r_rx[7:1]} : {r_rx[6:0], miso};
                if ((r_state == ST_DONE) && w_tick) begin
                    r_ss        <= 1'b1;
                    r_tip       <= 1'b0;
                    r_rx_vld    <= 1'b1;
                    r_miso_data <= r_rx;
                    r_mosi      <= 1'b0;
                    r_sclk      <= cpol;
                end
            end
        end
    end

    assign sclk         = r_sclk;
    assign mosi         = r_mosi;
    assign ss           = r_ss;
    assign tip          = r_tip;
    assign receive_data = r_rx_vld;
    assign miso_data    = r_miso_data;

endmodule

// File: tb/tb_spi_transfer_ctrl.sv
// Scoreboard bench for spi_transfer_ctrl: stimulus queues expected results, a monitor checks each completed byte.
module tb_spi_transfer_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       send_data;
    logic [7:0] mosi_data;
    logic       mstr, cpol, cpha, lsbfe, spiswai;
    logic [1:0] spi_mode;
    logic [2:0] spr, sppr;
    logic       miso;
    logic       sclk, mosi, ss, tip, receive_data;
    logic [7:0] miso_data;

    spi_transfer_ctrl dut (
        .PCLK(PCLK), .PRESET(PRESET), .send_data(send_data), .mosi_data(mosi_data),
        .mstr(mstr), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .spiswai(spiswai),
        .spi_mode(spi_mode), .spr(spr), .sppr(sppr), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss(ss), .tip(tip), .receive_data(receive_data),
        .miso_data(miso_data)
    );

    always #5 PCLK = ~PCLK;

    // slave model: loopback, or a shift-out byte advanced on each sclk leading edge
    logic       loop_en = 1'b1;
    logic [7:0] s_byte = 8'h00;
    logic       s_bit = 1'b0;
    logic [2:0] s_idx = 3'd0;
    logic       s_sclk_d = 1'b0;
    assign miso = loop_en ? mosi : s_bit;

    always @(posedge PCLK) begin
        if (ss) begin
            s_idx <= 3'd0;
        end else if ((s_sclk_d == cpol) && (sclk != cpol)) begin
            s_bit <= lsbfe ? s_byte[s_idx] : s_byte[3'd7 - s_idx];
            s_idx <= s_idx + 3'd1;
        end
        s_sclk_d <= sclk;
    end

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         len;
        int         first;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // monitor
    logic       m_tip_d = 1'b0;
    logic       m_sclk_d = 1'b0;
    int         m_tcnt = 0;
    int         m_first = -1;
    int         m_nrise = 0;
    logic [7:0] m_cap = 8'h00;
    exp_t       m_e;

    always @(negedge PCLK) begin
        if (PRESET) begin
            m_tip_d  = 1'b0;
            m_sclk_d = sclk;
        end else begin
            if (tip && !m_tip_d) begin
                m_tcnt  = 0;
                m_first = -1;
                m_nrise = 0;
                m_cap   = 8'h00;
            end
            if (tip) m_tcnt++;
            if (tip && (sclk !== m_sclk_d)) begin
                if (m_first < 0) m_first = m_tcnt - 1;
                if (sclk) m_nrise++;
                if ((sclk != cpol) != cpha)
                    m_cap = lsbfe ? {mosi, m_cap[7:1]} : {m_cap[6:0], mosi};
            end
            if (receive_data) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx: receive_data pulse with miso_data=0x%0h, expected none", miso_data);
                end else begin
                    m_e = sb.pop_front();
                    chk("miso_data", {24'd0, miso_data}, {24'd0, m_e.rx});
                    chk("mosi_bits", {24'd0, m_cap}, {24'd0, m_e.tx});
                    chk("tip_len", m_tcnt, m_e.len);
                    chk("first_sclk", m_first, m_e.first);
                    chk("sclk_rises", m_nrise, 8);
                end
            end
            m_tip_d  = tip;
            m_sclk_d = sclk;
        end
    end

    task automatic setup_cfg(input logic c_pol, input logic c_pha, input logic c_lsb,
                             input logic [2:0] c_sppr, input logic [2:0] c_spr,
                             input logic lp, input logic [7:0] sbyte);
        @(negedge PCLK);
        cpol = c_pol; cpha = c_pha; lsbfe = c_lsb;
        sppr = c_sppr; spr = c_spr; loop_en = lp; s_byte = sbyte;
        repeat (2) @(negedge PCLK);
    endtask

    task automatic start(input logic [7:0] tx, input logic [7:0] exp_rx, input int h, input int extra);
        exp_t e;
        e.rx = exp_rx; e.tx = tx; e.len = 18 * h + extra; e.first = 2 * h;
        sb.push_back(e);
        mosi_data = tx;
        send_data = 1'b1;
        @(negedge PCLK);
        send_data = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (tip && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        if (tip) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: tip still high after %0d cycles, expected low", nm, budget);
        end
        repeat (3) @(negedge PCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic sp;
        int   tog;
        int   n;
        exp_t e;

        PRESET = 1'b1; send_data = 1'b0; mosi_data = 8'h00;
        mstr = 1'b1; cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; spiswai = 1'b0;
        spi_mode = 2'b00; spr = 3'd0; sppr = 3'd0;
        #12;
        chk("rst_sclk", {31'd0, sclk}, 0);
        chk("rst_ss", {31'd0, ss}, 1);
        chk("rst_tip", {31'd0, tip}, 0);
        chk("rst_mosi", {31'd0, mosi}, 0);
        chk("rst_rx", {31'd0, receive_data}, 0);
        chk("rst_miso_data", {24'd0, miso_data}, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("idle_sclk_cpol", {31'd0, sclk}, 1);

        // H=1, mode 0, MSB first, loopback
        setup_cfg(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 8'h00);
        start(8'hA5, 8'hA5, 1, 0);
        wait_idle(40, "a5");

        // H=6, cpol=1 cpha=1, LSB first, slave returns 0x5C
        setup_cfg(1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 1'b0, 8'h5C);
        chk("idle_sclk_high", {31'd0, sclk}, 1);
        start(8'h3C, 8'h5C, 6, 0);
        wait_idle(200, "3c");

        // H=2, cpol=0 cpha=1, MSB first, slave returns 0xC3
        setup_cfg(1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 8'hC3);
        start(8'h81, 8'hC3, 2, 0);
        wait_idle(60, "81");

        // H=3, cpol=1 cpha=0, LSB first, loopback
        setup_cfg(1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b1, 8'h00);
        start(8'h6B, 8'h6B, 3, 0);
        wait_idle(80, "6b");

        // ignored requests
        setup_cfg(1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 8'h00);
        mstr = 1'b0; mosi_data = 8'hEE; send_data = 1'b1;
        @(negedge PCLK); send_data = 1'b0;
        chk("ign_mstr_tip", {31'd0, tip}, 0);
        chk("ign_mstr_ss", {31'd0, ss}, 1);
        mstr = 1'b1; spi_mode = 2'b10; send_data = 1'b1;
        @(negedge PCLK); send_data = 1'b0;
        chk("ign_stop_tip", {31'd0, tip}, 0);
        spi_mode = 2'b00;
        @(negedge PCLK);
        start(8'h4D, 8'h4D, 2, 0);
        repeat (10) @(negedge PCLK);
        mosi_data = 8'hFF; send_data = 1'b1;
        @(negedge PCLK); send_data = 1'b0;
        wait_idle(60, "4d");
        repeat (10) @(negedge PCLK);
        chk("ign_mid_no_restart", {31'd0, tip}, 0);

        // back-to-back: request during the receive_data cycle is dropped, next cycle accepted
        setup_cfg(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 8'h00);
        start(8'h3E, 8'h3E, 1, 0);
        n = 0;
        while (!receive_data && n < 40) begin
            @(negedge PCLK);
            n++;
        end
        chk("b2b_rx_seen", {31'd0, receive_data}, 1);
        e.rx = 8'hC5; e.tx = 8'hC5; e.len = 18; e.first = 2;
        sb.push_back(e);
        mosi_data = 8'hC5; send_data = 1'b1;
        @(posedge PCLK); #1;
        chk("b2b_ignored_tip", {31'd0, tip}, 0);
        @(posedge PCLK); #1;
        chk("b2b_restart_tip", {31'd0, tip}, 1);
        @(negedge PCLK); send_data = 1'b0;
        wait_idle(40, "c5");

        // wait-mode request mid transfer at H=1
        setup_cfg(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 8'h00);
`ifdef SPI_WAIT_FREEZE_EN
        start(8'h96, 8'h96, 1, 20);
`else
        start(8'h96, 8'h96, 1, 0);
`endif
        repeat (5) @(negedge PCLK);
        spi_mode = 2'b01; spiswai = 1'b1;
        repeat (20) @(negedge PCLK);
        spi_mode = 2'b00; spiswai = 1'b0;
        wait_idle(60, "96");

        // reset at edge 7 aborts the transfer
        setup_cfg(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 8'h00);
        mosi_data = 8'h77; send_data = 1'b1;
        @(negedge PCLK); send_data = 1'b0;
        sp = sclk; tog = 0;
        for (int i = 0; i < 100 && tog < 8; i++) begin
            @(negedge PCLK);
            if (sclk !== sp) begin
                tog++;
                sp = sclk;
            end
        end
        chk("rst_edge7_reached", tog, 8);
        #1 PRESET = 1'b1;
        #1;
        chk("abort_ss", {31'd0, ss}, 1);
        chk("abort_tip", {31'd0, tip}, 0);
        chk("abort_sclk", {31'd0, sclk}, 0);
        chk("abort_miso_data", {24'd0, miso_data}, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("post_rst_sclk_cpol", {31'd0, sclk}, 1);
        repeat (30) @(negedge PCLK);
        chk("abort_no_rx_tip", {31'd0, tip}, 0);

        // H=1024
        setup_cfg(1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 1'b1, 8'h00);
        start(8'h5A, 8'h5A, 1024, 0);
        wait_idle(19000, "h1024");

        repeat (10) @(negedge PCLK);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_transfer_ctrl.md
SPI_TRANSFER_CTRL -- requirements
Module: spi_transfer_ctrl

Interface
REQ-001 PCLK  input  1  system clock; all state updates on rising edge.
REQ-002 PRESET  input  1  asynchronous, active-high reset.
REQ-003 send_data  input  1  one-cycle start request from the APB slave interface.
REQ-004 mosi_data  input  8  byte to transmit; captured when a transfer starts.
REQ-005 mstr, cpol, cpha, lsbfe, spiswai  input  1 each  control bits from the control register.
REQ-006 spi_mode  input  2  00 = run, 01 = wait, 10/11 = stop.
REQ-007 spr, sppr  input  3 each  baud rate select and prescaler select.
REQ-008 miso  input  1  serial data in.
REQ-009 sclk, mosi, ss  output  1 each  SPI clock, serial data out, active-low slave select.
REQ-010 tip  output  1  transfer in progress.
REQ-011 receive_data  output  1  one-cycle pulse marking a completed byte.
REQ-012 miso_data  output  8  last received byte.

Function
REQ-013 Half-period H SHALL be (sppr+1) << spr PCLK cycles, range 1..1024, held in an 11-bit counter.
REQ-014 The state machine SHALL have four states: IDLE, SETUP, XFER, DONE.
REQ-015 IDLE -> SETUP SHALL occur on a PCLK edge where send_data=1, mstr=1 and spi_mode=00; at that edge mosi_data is latched, and ss=0 and tip=1 are registered.
REQ-016 send_data SHALL be ignored when mstr=0, when spi_mode!=00, or when the state is not IDLE; requests are not queued.
REQ-017 SETUP SHALL last H cycles with sclk=cpol, then go to XFER.
REQ-018 XFER SHALL toggle sclk every H cycles, producing 16 edges counted 0..15.
  - Even-indexed edges are leading edges; odd-indexed edges are trailing edges.
REQ-019 When cpha=0:
  - the first bit is driven on mosi on entry to SETUP;
  - miso is sampled on leading edges;
  - mosi shifts on trailing edges 1..13; no shift after edge 15.
REQ-020 When cpha=1:
  - mosi shifts on leading edges, with the first bit driven at edge 0;
  - miso is sampled on trailing edges.
REQ-021 Bit order: lsbfe=1 sends and receives LSB first; lsbfe=0 sends and receives MSB first. Received bits SHALL be assembled in true bit order.
REQ-022 After edge 15 the block SHALL enter DONE. DONE lasts H cycles with sclk=cpol; at its final edge:
  - ss=1 and tip=0;
  - miso_data is loaded;
  - receive_data=1 for exactly one cycle;
  - the state returns to IDLE.
REQ-023 Total transfer time SHALL be 18*H cycles, measured from the tip rising edge to the tip falling edge.
REQ-024 In IDLE: sclk=cpol, ss=1, tip=0, mosi=0.
REQ-025 A cpol change during a transfer SHALL take effect only in IDLE.
REQ-026 A back-to-back send_data in the same cycle that receive_data is high SHALL be ignored; the earliest accepted restart is the following cycle.

Reset
REQ-027 PRESET=1 SHALL asynchronously force:
  - state=IDLE, sclk=0, mosi=0, ss=1, tip=0;
  - receive_data=0, miso_data=8'h00;
  - all counters and shift registers to 0.
REQ-028 Reset during a transfer SHALL abort it without a receive_data pulse. After release, sclk SHALL follow cpol from the first PCLK edge.

Configuration
REQ-029 Macro SPI_WAIT_FREEZE_EN defined: while spi_mode=01 and spiswai=1, the baud counter, edge counter and FSM SHALL freeze, holding sclk, ss and tip; they resume exactly where they stopped when either condition clears.
REQ-030 Macro SPI_WAIT_FREEZE_EN undefined: spiswai SHALL be ignored, and a transfer already in progress SHALL always complete regardless of spi_mode.

Verification
REQ-031 sppr=0, spr=0, cpol=0, cpha=0, lsbfe=0, mosi_data=8'hA5, miso looped to mosi -> 8 sclk rising edges; mosi sequence 1,0,1,0,0,1,0,1; tip high 18 cycles; one receive_data pulse; miso_data=8'hA5.
REQ-032 sppr=2, spr=1 (H=6), cpol=1, cpha=1, lsbfe=1, mosi_data=8'h3C, slave model returns 8'h5C -> sclk idles high; LSB first on mosi; tip high 108 cycles; miso_data=8'h5C.
REQ-033 send_data pulsed with mstr=0, then with spi_mode=10, then mid-transfer -> no new transfer starts; the in-flight transfer completes unchanged with exactly one receive_data pulse.
REQ-034 PRESET asserted at edge 7 of a transfer -> ss=1, tip=0, sclk=0 immediately; no receive_data pulse; miso_data=8'h00.
REQ-035 With SPI_WAIT_FREEZE_EN, spi_mode=01 and spiswai=1 for 20 cycles mid-XFER at H=1 -> sclk static for 20 cycles; tip high for 38 cycles total; data correct. Without the macro -> tip high for 18 cycles.
REQ-036 H=1024 (sppr=7, spr=7) -> first sclk toggle 2048 cycles after tip rises; counter does not overflow; total transfer time 18432 cycles.
